// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a valid/ready LSU port.
// Requests are accepted in IDLE. They wait LATENCY cycles, then commit on the edge into RESP.
// The response is held until it is taken.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module dmem_responder #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_store,
    input  logic [7:0]  req_mask,
    input  logic [1:0]  req_sext,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        store_q;
    logic [7:0]  mask_q;
    logic [1:0]  sext_q;
    logic        latch_en, commit;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH];

    // Commit-time operands: live inputs when LATENCY=0 commits straight from IDLE
    logic [31:0] c_addr, c_wdata;
    logic        c_store;
    logic [7:0]  c_mask;
    logic [1:0]  c_sext;
    logic [31:0] off;
    logic [1:0]  lane;
    logic [IW-1:0] idx;
    logic        range_err, misalign, err;
    logic [3:0]  mask4, lane_en;
    logic [31:0] cur, wsh, wr_word, raw, masked, ld;

    assign c_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign c_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
    assign c_store = (state_q == StIdle) ? req_store : store_q;
    assign c_mask  = (state_q == StIdle) ? req_mask  : mask_q;
    assign c_sext  = (state_q == StIdle) ? req_sext  : sext_q;

    assign off = c_addr - BASE;
    // BASE is word aligned, so off[1:0] equals addr[1:0]
    assign lane = off[1:0];
    assign idx  = off[IW+1:2];
    // DEPTH is a power of two: idx >= DEPTH iff any offset bit above the index is set
    assign range_err = (c_addr < BASE) || (off[31:IW+2] != '0);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = ((c_mask == 8'h03) && lane[0]) || ((c_mask == 8'h0F) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign err = range_err || misalign;

    // Lane-masked store data and shifted/extended load data
    always_comb begin
        unique case (c_mask)
            8'h03:   mask4 = 4'b0011;
            8'h0F:   mask4 = 4'b1111;
            default: mask4 = 4'b0001;
        endcase
        cur     = mem[idx];
        lane_en = mask4 << lane;
        wsh     = c_wdata << {lane, 3'b000};
        for (int b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = lane_en[b] ? wsh[8*b +: 8] : cur[8*b +: 8];
        end
        raw = cur >> {lane, 3'b000};
        unique case (mask4)
            4'b0011: masked = raw & 32'h0000_FFFF;
            4'b1111: masked = raw;
            default: masked = raw & 32'h0000_00FF;
        endcase
        unique case (c_sext)
            2'b01:   ld = {{24{masked[7]}}, masked[7:0]};
            2'b10:   ld = {{16{masked[15]}}, masked[15:0]};
            default: ld = masked;
        endcase
    end

    // Next-state and response logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch_en     = 1'b0;
        commit       = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    cnt_d    = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = err;
            resp_rdata_d = (err || c_store) ? 32'h0 : ld;
        end
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            store_q      <= 1'b0;
            mask_q       <= 8'h0;
            sext_q       <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (latch_en) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                store_q <= req_store;
                mask_q  <= req_mask;
                sext_q  <= req_sext;
            end
        end
    end

    // Storage write on the commit edge; contents are never reset
    always_ff @(posedge clk) begin
        if (!rst && commit && c_store && !err) begin
            mem[idx] <= wr_word;
        end
    end

    assign req_ready  = (state_q == StIdle) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance (a) and a LATENCY=0 instance (b).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_a, req_ready_b;
    logic [31:0] req_addr = 32'h0;
    logic        req_store = 1'b0;
    logic [7:0]  req_mask = 8'h0;
    logic [1:0]  req_sext = 2'b00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid_a, resp_valid_b;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata_a, resp_rdata_b;
    logic        resp_err_a, resp_err_b;

    int checks = 0;
    int failures = 0;
    bit sel = 1'b0;

    always #5 clk = ~clk;

    dmem_responder u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr), .req_store(req_store), .req_mask(req_mask), .req_sext(req_sext),
        .req_wdata(req_wdata), .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    dmem_responder #(.LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_store(req_store), .req_mask(req_mask), .req_sext(req_sext),
        .req_wdata(req_wdata), .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    wire        rdy_s   = sel ? req_ready_b  : req_ready_a;
    wire        rv_s    = sel ? resp_valid_b : resp_valid_a;
    wire [31:0] rdata_s = sel ? resp_rdata_b : resp_rdata_a;
    wire        err_s   = sel ? resp_err_b   : resp_err_a;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic        EXP_MIS_ERR  = 1'b1;
    localparam logic [31:0] EXP_MIS_WORD = 32'hAABB_CCDD;
`else
    localparam logic        EXP_MIS_ERR  = 1'b0;
    localparam logic [31:0] EXP_MIS_WORD = 32'h3344_CCDD;
`endif

    typedef struct {
        bit          sel;
        logic [31:0] addr;
        logic        st;
        logic [7:0]  mask;
        logic [1:0]  sext;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on the selected instance and collect its response
    task automatic run_req(input bit s, input logic [31:0] addr, input logic st,
                           input logic [7:0] mask, input logic [1:0] sext, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        sel = s;
        req_addr = addr; req_store = st; req_mask = mask; req_sext = sext; req_wdata = wd;
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        #1 check("req_ready_before_accept", 32'(rdy_s), 32'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat = 0;
        while (!rv_s && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rdata_s;
        er = err_s;
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{0, 32'h8000_0010, 1'b1, 8'h0F, 2'b00, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{0, 32'h8000_0010, 1'b0, 8'h0F, 2'b00, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{0, 32'h8000_0011, 1'b0, 8'h01, 2'b01, 32'h0, 32'hFFFF_FFBE, 1'b0};
        vecs[3]  = '{0, 32'h8000_0011, 1'b0, 8'h01, 2'b00, 32'h0, 32'h0000_00BE, 1'b0};
        vecs[4]  = '{0, 32'h8000_0012, 1'b0, 8'h03, 2'b10, 32'h0, 32'hFFFF_DEAD, 1'b0};
        vecs[5]  = '{0, 32'h8000_0013, 1'b1, 8'h01, 2'b00, 32'h0000_0055, 32'h0, 1'b0};
        vecs[6]  = '{0, 32'h8000_0010, 1'b0, 8'h0F, 2'b00, 32'h0, 32'h55AD_BEEF, 1'b0};
        vecs[7]  = '{0, 32'h8000_0000, 1'b1, 8'h0F, 2'b00, 32'h1234_5678, 32'h0, 1'b0};
        vecs[8]  = '{0, 32'h7FFF_FFFC, 1'b0, 8'h0F, 2'b00, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{0, 32'h8000_1000, 1'b0, 8'h0F, 2'b00, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{0, 32'h8000_1000, 1'b1, 8'h0F, 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[11] = '{0, 32'h8000_0000, 1'b0, 8'h0F, 2'b00, 32'h0, 32'h1234_5678, 1'b0};
        vecs[12] = '{0, 32'h8000_0012, 1'b0, 8'h03, 2'b00, 32'h0, 32'h0000_55AD, 1'b0};
        vecs[13] = '{0, 32'h8000_0010, 1'b0, 8'h07, 2'b11, 32'h0, 32'h0000_00EF, 1'b0};
        vecs[14] = '{0, 32'h8000_0013, 1'b0, 8'h01, 2'b10, 32'h0, 32'h0000_0055, 1'b0};
        vecs[15] = '{1, 32'h8000_0000, 1'b1, 8'h0F, 2'b00, 32'hAABB_CCDD, 32'h0, 1'b0};
        vecs[16] = '{1, 32'h8000_0002, 1'b1, 8'h0F, 2'b00, 32'h1122_3344, 32'h0, EXP_MIS_ERR};
        vecs[17] = '{1, 32'h8000_0000, 1'b0, 8'h0F, 2'b00, 32'h0, EXP_MIS_WORD, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready_a), 32'd0);
        check("reset_resp_valid", 32'(resp_valid_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_req_ready", 32'(req_ready_a), 32'd1);
        check("post_reset_rdata", resp_rdata_a, 32'h0);
        check("post_reset_err", 32'(resp_err_a), 32'd0);

        foreach (vecs[i]) begin
            run_req(vecs[i].sel, vecs[i].addr, vecs[i].st, vecs[i].mask, vecs[i].sext,
                    vecs[i].wd, rd, er, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].sel ? 32'd0 : 32'd2);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_released", i), 32'(rv_s), 32'd0);
        end

        // Back-pressure: response frozen while resp_ready is low, then reset
        resp_ready = 1'b0;
        run_req(1'b0, 32'h8000_0010, 1'b0, 8'h0F, 2'b00, 32'h0, rd, er, lat);
        check("bp_latency", lat, 32'd2);
        check("bp_rdata", rd, 32'h55AD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_valid_%0d", k), 32'(resp_valid_a), 32'd1);
            check($sformatf("bp_rdata_%0d", k), resp_rdata_a, 32'h55AD_BEEF);
            check($sformatf("bp_err_%0d", k), 32'(resp_err_a), 32'd0);
            check($sformatf("bp_req_ready_%0d", k), 32'(req_ready_a), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
        check("rst_rdata", resp_rdata_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1 check("rst_req_ready_after", 32'(req_ready_a), 32'd1);

        // In-flight store discarded by reset before its commit edge
        @(negedge clk);
        sel = 1'b0;
        req_addr = 32'h8000_0000; req_store = 1'b1; req_mask = 8'h0F; req_wdata = 32'hCAFE_F00D;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("discard_resp_valid", 32'(resp_valid_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_req(1'b0, 32'h8000_0000, 1'b0, 8'h0F, 2'b00, 32'h0, rd, er, lat);
        check("discard_word0", rd, 32'h1234_5678);
        check("discard_err", 32'(er), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
